pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the 16-bit CPU: holds the architectural PC, issues instruction fetches to instruction memory over a req/ack handshake, and delivers fetched instructions to decode over a valid/ready handshake. It consumes the PC+2 increment and the branch, jump, call and return redirects produced downstream, and maintains a small return-address stack. It sits between instruction memory and the decoder, replacing a free-running PC register.

## Interface

**Parameters**
- `RESET_PC`: default `16'h0000`. PC loaded on reset; also the return target on stack underflow.
- `RAS_DEPTH`: default `4`. Number of return-address-stack entries. Must be a power of 2, ≥2.

**Ports**
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `imem_req` output 1: fetch request.
- `imem_addr` output 16: fetch byte address (always even).
- `imem_ack` input 1: fetch complete; `imem_data` is valid this cycle.
- `imem_data` input 16: fetched instruction word.
- `instr_valid` output 1: instruction available to decode.
- `instr` output 16: instruction word.
- `instr_pc` output 16: address of `instr`.
- `instr_ready` input 1: decode accepts the instruction.
- `redirect` input 1: single-cycle redirect strobe.
- `redirect_kind` input 2: redirect type. 00 = branch (relative), 01 = jump (absolute), 10 = call (absolute), 11 = return.
- `redirect_base` input 16: PC of the redirecting instruction.
- `redirect_target` input 16: signed word offset (branch) or absolute byte address (jump/call). Ignored for return.
- `halt` input 1: level request to stop fetching.
- `halted` output 1: sequencer is idle in HALT.
- `ras_overflow` output 1: sticky flag, set on a push to a full stack.
- `ras_underflow` output 1: sticky flag, set on a pop from an empty stack.

## Operation

**States:** FETCH, DELIVER, HALT.

- **FETCH**
  - `imem_req`=1 and `imem_addr`=PC. Both are held stable until `imem_ack`.
  - On ack: `instr`←`imem_data`, `instr_pc`←PC, go to DELIVER.
  - If the squash flag is set, the acked data is dropped, squash clears, and the state stays in FETCH with the new PC.
- **DELIVER**
  - `instr_valid`=1.
  - On `instr_valid && instr_ready`: PC←PC+2 (mod 2^16), then go to FETCH, or to HALT if `halt` is high.
- **HALT**
  - `imem_req`=0, `instr_valid`=0, `halted`=1.
  - When `halt` falls, go to FETCH at the current PC.
- **Halt in FETCH:** a pending request always completes and delivers first. Halt is honoured only at a DELIVER accept.

**Redirect targets** (all arithmetic is 16-bit and wraps):
- branch: `redirect_base + 2 + (redirect_target << 1)`
- jump: `redirect_target`
- call: `redirect_target`; push `redirect_base + 2`.
- return: pop top of stack. If the stack is empty, the target is `RESET_PC` and `ras_underflow` is set.
- Bit 0 of the computed target is forced to 0.

**Redirect effect** (accepted in any state):
- PC←target and `instr_valid` drops next cycle.
- From FETCH with the request not acked this cycle: set squash. The request stays up at the old address until ack; the data is discarded, then the fetch is reissued at the target.
- From FETCH with the request acked this cycle: discard the data.
- From HALT: PC updates and the state stays in HALT.

**Simultaneous events:**
- Redirect beats a DELIVER accept in the same cycle. The accept still counts as consumed, but PC takes the target, not PC+2.
- Redirect with `halt`: apply the redirect, then go to HALT.

**Return-address stack:** circular buffer of `RAS_DEPTH` entries.
- A push when full overwrites the oldest entry and sets `ras_overflow`.
- The flags clear only on reset.

## Timing

**Reset values** (`rst_n` low, asynchronous): PC=`RESET_PC`, state=FETCH, squash=0, stack empty, flags 0.
- Outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=0, `instr_pc`=0, `halted`=0.
- `imem_req` is gated low while in reset and rises in the first cycle after `rst_n` deasserts.
- Reset asserted mid-fetch drops `imem_req` immediately. The lost ack is ignored.

**Latency:**
- With `imem_ack` in the same cycle as req and `instr_ready`=1: one instruction every 2 cycles. The request for PC+2 rises the cycle after accept.
- Redirect registered at edge N: `imem_addr`=target at edge N+1, or after the squashed ack arrives.
- `halted` rises the cycle after the accept that enters HALT. It falls the cycle after `halt` deasserts.

## Structure

- **Package `pc_pkg`:**
  - Redirect-kind constants: `RD_BRANCH`, `RD_JUMP`, `RD_CALL`, `RD_RETURN`.
  - State enum.
  - `INSTR_BYTES`=2.
- **Sub-module `return_stack`:** push, pop, top, empty, full, and an overflow pulse, parameterized by `RAS_DEPTH`.
- **Top level:** the FSM, the PC register, the target adder and the output registers.

## Test plan

1. **Reset and sequential fetch:** reset, `RESET_PC`=0, zero-wait memory, `instr_ready`=1 → addresses 0,2,4,6 on successive requests; `instr_pc` matches; one instruction per 2 cycles.
2. **Wrap-around:** PC=`16'hFFFE`, accept → next `imem_addr`=`16'h0000`. Branch from base `16'hFFFC` with offset 1 → target `16'h0000`.
3. **Branch during a stalled fetch:** ack delayed 3 cycles, branch base=`16'h0010`, offset=-4 → stale data dropped, no `instr_valid`, next request at `16'h000A`.
4. **Call/return nesting to depth 5 with `RAS_DEPTH`=4:**
   - Calls from bases 0x100, 0x200, 0x300, 0x400, 0x500 → `ras_overflow`=1.
   - Four returns → 0x502, 0x402, 0x302, 0x202.
   - Fifth return → `RESET_PC` with `ras_underflow`=1.
5. **Halt with decode backpressure:** `halt` high while `instr_ready`=0 in DELIVER → stays in DELIVER. Accept → HALT, `halted`=1, no requests. `halt` low → fetch resumes at PC+2.
6. **Async reset mid-fetch:** `rst_n` low while `imem_req`=1 → `imem_req`=0 the same cycle, all outputs at reset values. After release, the first request is at `RESET_PC`.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: redirect kinds, FSM
// states and the instruction step size.
package pc_pkg;

   localparam int PC_W = 16;

   localparam logic [1:0] RD_BRANCH = 2'b00;
   localparam logic [1:0] RD_JUMP   = 2'b01;
   localparam logic [1:0] RD_CALL   = 2'b10;
   localparam logic [1:0] RD_RETURN = 2'b11;

   localparam logic [PC_W-1:0] INSTR_BYTES = 16'd2;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_DELIVER = 2'd1,
      ST_HALT    = 2'd2
   } state_e;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry and pulses overflow_o; a pop from an empty stack is ignored.
module return_stack
   import pc_pkg::*;
#(
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [PC_W-1:0] push_data_i,
   output logic [PC_W-1:0] top_o,
   output logic            empty_o,
   output logic            full_o,
   output logic            overflow_o
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

   logic [PW-1:0]   ptr_q;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   cnt_q;
   logic [PC_W-1:0] mem_q [RAS_DEPTH];

   // ptr_q always indexes the most recent entry; the slot after it is the
   // oldest one once the stack is full, so wrapping overwrites it naturally.
   assign wr_ptr     = ptr_q + PW'(1);
   assign empty_o    = (cnt_q == '0);
   assign full_o     = (cnt_q == DEPTH_C);
   assign overflow_o = push_i && full_o;
   assign top_o      = mem_q[ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else if (push_i) begin
         ptr_q <= wr_ptr;
         if (!full_o) cnt_q <= cnt_q + CW'(1);
      end else if (pop_i && !empty_o) begin
         ptr_q <= ptr_q - PW'(1);
         cnt_q <= cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr] <= push_data_i;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches over req/ack, hands instructions to
// decode over valid/ready, and applies branch/jump/call/return redirects.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int          RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_data,
   output logic        instr_valid,
   output logic [15:0] instr,
   output logic [15:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [1:0]  redirect_kind,
   input  logic [15:0] redirect_base,
   input  logic [15:0] redirect_target,
   input  logic        halt,
   output logic        halted,
   output logic        ras_overflow,
   output logic        ras_underflow
);

   state_e          state_q;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] addr_q;
   logic [PC_W-1:0] instr_q;
   logic [PC_W-1:0] instr_pc_q;
   logic            squash_q;
   logic            req_q;
   logic            valid_q;
   logic            halted_q;
   logic            ovf_q;
   logic            unf_q;

   logic            fetch_ack;
   logic            is_call;
   logic            is_return;
   logic            ras_pop;
   logic            rs_empty;
   logic            rs_overflow;
   logic            rs_full_unused;
   logic [PC_W-1:0] rs_top;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] deliver_pc;

   // An ack only counts against a request we are actually presenting; this
   // also discards an ack that belonged to a fetch cut short by reset.
   assign fetch_ack  = (state_q == ST_FETCH) && req_q && imem_ack;
   assign is_call    = redirect && (redirect_kind == RD_CALL);
   assign is_return  = redirect && (redirect_kind == RD_RETURN);
   assign ras_pop    = is_return && !rs_empty;
   assign deliver_pc = redirect ? target : pc_q + INSTR_BYTES;

   return_stack #(
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (is_call),
      .pop_i       (ras_pop),
      .push_data_i (redirect_base + INSTR_BYTES),
      .top_o       (rs_top),
      .empty_o     (rs_empty),
      .full_o      (rs_full_unused),
      .overflow_o  (rs_overflow)
   );

   always_comb begin
      target = '0;
      unique case (redirect_kind)
         RD_BRANCH: target = redirect_base + INSTR_BYTES
                             + {redirect_target[PC_W-2:0], 1'b0};
         RD_JUMP,
         RD_CALL:   target = redirect_target;
         default:   target = rs_empty ? RESET_PC : rs_top;
      endcase
      target[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_FETCH;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         squash_q   <= 1'b0;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         halted_q   <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         if (rs_overflow)           ovf_q <= 1'b1;
         if (is_return && rs_empty) unf_q <= 1'b1;

         unique case (state_q)
            ST_FETCH: begin
               if (fetch_ack) begin
                  if (redirect) begin
                     pc_q     <= target;
                     addr_q   <= target;
                     squash_q <= 1'b0;
                     if (halt) begin
                        state_q  <= ST_HALT;
                        req_q    <= 1'b0;
                        halted_q <= 1'b1;
                     end
                  end else if (squash_q) begin
                     // Stale data from before the redirect: reissue at the new PC.
                     squash_q <= 1'b0;
                     addr_q   <= pc_q;
                  end else begin
                     instr_q    <= imem_data;
                     instr_pc_q <= pc_q;
                     state_q    <= ST_DELIVER;
                     req_q      <= 1'b0;
                     valid_q    <= 1'b1;
                  end
               end else begin
                  req_q <= 1'b1;
                  if (redirect) begin
                     pc_q <= target;
                     // An outstanding request must finish at its old address.
                     if (req_q) squash_q <= 1'b1;
                     else       addr_q   <= target;
                  end
               end
            end

            ST_DELIVER: begin
               // A redirect consumes the instruction even without ready.
               if (redirect || instr_ready) begin
                  pc_q    <= deliver_pc;
                  addr_q  <= deliver_pc;
                  valid_q <= 1'b0;
                  if (halt) begin
                     state_q  <= ST_HALT;
                     halted_q <= 1'b1;
                  end else begin
                     state_q <= ST_FETCH;
                     req_q   <= 1'b1;
                  end
               end
            end

            ST_HALT: begin
               if (redirect) begin
                  pc_q   <= target;
                  addr_q <= target;
               end
               if (!halt) begin
                  state_q  <= ST_FETCH;
                  req_q    <= 1'b1;
                  halted_q <= 1'b0;
               end
            end

            default: begin
               state_q  <= ST_FETCH;
               req_q    <= 1'b1;
               valid_q  <= 1'b0;
               halted_q <= 1'b0;
               squash_q <= 1'b0;
               addr_q   <= pc_q;
            end
         endcase
      end
   end

   assign imem_req      = req_q;
   assign imem_addr     = addr_q;
   assign instr_valid   = valid_q;
   assign instr         = instr_q;
   assign instr_pc      = instr_pc_q;
   assign halted        = halted_q;
   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized bench for pc_sequencer against a cycle-level
// behavioural model that keeps the return stack as a queue.
module tb_pc_sequencer;

   localparam logic [15:0] RESET_PC  = 16'h0000;
   localparam int          RAS_DEPTH = 4;
   localparam int          PH_F = 0;
   localparam int          PH_D = 1;
   localparam int          PH_H = 2;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic        instr_valid;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_ready;
   logic        redirect;
   logic [1:0]  redirect_kind;
   logic [15:0] redirect_base;
   logic [15:0] redirect_target;
   logic        halt;
   logic        halted;
   logic        ras_overflow;
   logic        ras_underflow;

   pc_sequencer #(
      .RESET_PC  (RESET_PC),
      .RAS_DEPTH (RAS_DEPTH)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_data       (imem_data),
      .instr_valid     (instr_valid),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .instr_ready     (instr_ready),
      .redirect        (redirect),
      .redirect_kind   (redirect_kind),
      .redirect_base   (redirect_base),
      .redirect_target (redirect_target),
      .halt            (halt),
      .halted          (halted),
      .ras_overflow    (ras_overflow),
      .ras_underflow   (ras_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int ack_prob = 100;

   // Model state
   int          mph;
   logic [15:0] mpc;
   logic        msq;
   logic [15:0] mstale;
   logic        mjr;
   logic [15:0] mbi;
   logic [15:0] mbp;
   logic        movf;
   logic        munf;
   logic [15:0] ras[$];

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h1357;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mph = PH_F; mpc = RESET_PC; msq = 1'b0; mstale = RESET_PC; mjr = 1'b1;
      mbi = '0; mbp = '0; movf = 1'b0; munf = 1'b0;
      ras.delete();
   endtask

   task automatic model_edge();
      bit          acked;
      logic [15:0] t;
      acked = (mph == PH_F) && !mjr && imem_ack;
      t = '0;
      if (redirect) begin
         case (redirect_kind)
            2'b00: t = redirect_base + 16'd2 + 16'(redirect_target * 2);
            2'b01: t = redirect_target;
            2'b10: begin
               t = redirect_target;
               ras.push_back(redirect_base + 16'd2);
               if (ras.size() > RAS_DEPTH) begin
                  void'(ras.pop_front());
                  movf = 1'b1;
               end
            end
            default: begin
               if (ras.size() == 0) begin
                  t = RESET_PC;
                  munf = 1'b1;
               end else begin
                  t = ras.pop_back();
               end
            end
         endcase
         t[0] = 1'b0;
      end
      case (mph)
         PH_F: begin
            if (acked) begin
               if (redirect) begin
                  mpc = t; msq = 1'b0;
                  if (halt) mph = PH_H;
               end else if (msq) begin
                  msq = 1'b0;
               end else begin
                  mbi = mem_word(mpc); mbp = mpc; mph = PH_D;
               end
            end else if (redirect) begin
               if (!mjr && !msq) begin
                  mstale = mpc;
                  msq = 1'b1;
               end
               mpc = t;
            end
         end
         PH_D: begin
            if (redirect || instr_ready) begin
               mpc = redirect ? t : mpc + 16'd2;
               mph = halt ? PH_H : PH_F;
            end
         end
         default: begin
            if (redirect) mpc = t;
            if (!halt) mph = PH_F;
         end
      endcase
      mjr = 1'b0;
   endtask

   function automatic logic exp_req();
      return (mph == PH_F) && !mjr;
   endfunction

   task automatic check_all();
      chk("imem_req",      16'(imem_req),      16'(exp_req()));
      chk("imem_addr",     imem_addr,          msq ? mstale : mpc);
      chk("instr_valid",   16'(instr_valid),   16'(mph == PH_D));
      chk("instr",         instr,              mbi);
      chk("instr_pc",      instr_pc,           mbp);
      chk("halted",        16'(halted),        16'(mph == PH_H));
      chk("ras_overflow",  16'(ras_overflow),  16'(movf));
      chk("ras_underflow", 16'(ras_underflow), 16'(munf));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
      redirect  = 1'b0;
      imem_data = mem_word(imem_addr);
      imem_ack  = exp_req() && ($urandom_range(0, 99) < ack_prob);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!instr_valid && n < 20) begin
         cycle();
         n++;
      end
      chk("wait_valid", 16'(instr_valid), 16'd1);
   endtask

   task automatic redirect_at_deliver(input logic [1:0] k, input logic [15:0] b,
                                      input logic [15:0] t);
      wait_valid();
      redirect = 1'b1; redirect_kind = k; redirect_base = b; redirect_target = t;
      cycle();
   endtask

   logic [15:0] ret_exp [5];
   logic [15:0] held_pc;

   initial begin
      rst_n = 1'b0; imem_ack = 1'b0; imem_data = '0; instr_ready = 1'b0;
      redirect = 1'b0; redirect_kind = 2'b00; redirect_base = '0;
      redirect_target = '0; halt = 1'b0;
      model_reset();

      // Reset state and sequential fetch at zero wait states
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all();
      rst_n = 1'b1; instr_ready = 1'b1; ack_prob = 100;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("seq_req", 16'(imem_req), 16'd1);
         chk("seq_addr", imem_addr, 16'(i * 2));
         cycle();
         chk("seq_instr_pc", instr_pc, 16'(i * 2));
      end

      // Wrap-around of PC+2 and of a branch target
      redirect = 1'b1; redirect_kind = 2'b01; redirect_target = 16'hFFFE;
      cycle();
      chk("jump_addr", imem_addr, 16'hFFFE);
      cycle();
      cycle();
      chk("wrap_addr", imem_addr, 16'h0000);
      cycle();
      redirect = 1'b1; redirect_kind = 2'b00; redirect_base = 16'hFFFC;
      redirect_target = 16'h0001;
      cycle();
      chk("br_wrap_addr", imem_addr, 16'h0000);
      chk("br_wrap_valid", 16'(instr_valid), 16'd0);

      // Branch while a fetch is stalled: stale data must be dropped
      imem_ack = 1'b0; ack_prob = 0;
      redirect = 1'b1; redirect_kind = 2'b00; redirect_base = 16'h0010;
      redirect_target = 16'hFFFC;
      cycle();
      chk("stall_old_addr", imem_addr, 16'h0000);
      cycle();
      cycle();
      imem_ack = 1'b1;
      cycle();
      chk("squash_valid", 16'(instr_valid), 16'd0);
      chk("squash_addr", imem_addr, 16'h000A);
      ack_prob = 100; imem_ack = 1'b1;

      // Call nesting past the stack depth, then unwind
      for (int i = 1; i <= 5; i++)
         redirect_at_deliver(2'b10, 16'(i * 16'h0100), 16'h1000 + 16'(i * 16'h0040));
      chk("ras_overflow_set", 16'(ras_overflow), 16'd1);
      ret_exp[0] = 16'h0502; ret_exp[1] = 16'h0402; ret_exp[2] = 16'h0302;
      ret_exp[3] = 16'h0202; ret_exp[4] = RESET_PC;
      for (int i = 0; i < 5; i++) begin
         redirect_at_deliver(2'b11, 16'h2000, 16'hDEAD);
         chk("ret_addr", imem_addr, ret_exp[i]);
      end
      chk("ras_underflow_set", 16'(ras_underflow), 16'd1);

      // Halt under decode backpressure
      instr_ready = 1'b0;
      wait_valid();
      held_pc = instr_pc;
      halt = 1'b1;
      cycle();
      cycle();
      chk("halt_hold_valid", 16'(instr_valid), 16'd1);
      chk("halt_hold_halted", 16'(halted), 16'd0);
      instr_ready = 1'b1;
      cycle();
      chk("halted_set", 16'(halted), 16'd1);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("halt_no_req", 16'(imem_req), 16'd0);
      end
      halt = 1'b0;
      cycle();
      chk("resume_halted", 16'(halted), 16'd0);
      chk("resume_req", 16'(imem_req), 16'd1);
      chk("resume_addr", imem_addr, held_pc + 16'd2);

      // Asynchronous reset in the middle of a fetch
      #2;
      rst_n = 1'b0;
      imem_ack = 1'b1;
      #1;
      model_reset();
      chk("rst_req", 16'(imem_req), 16'd0);
      check_all();
      @(posedge clk);
      @(negedge clk);
      check_all();
      rst_n = 1'b1;
      imem_ack = 1'b1;
      cycle();
      chk("rst_first_req", 16'(imem_req), 16'd1);
      chk("rst_first_addr", imem_addr, RESET_PC);
      chk("rst_lost_ack_valid", 16'(instr_valid), 16'd0);

      // Randomized traffic
      ack_prob = 60;
      for (int i = 0; i < 1500; i++) begin
         instr_ready = ($urandom_range(0, 3) != 0);
         redirect = ($urandom_range(0, 7) == 0);
         redirect_kind = 2'($urandom_range(0, 3));
         redirect_base = 16'($urandom);
         redirect_target = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                                      : 16'($urandom_range(0, 15)) - 16'd8;
         if ($urandom_range(0, 15) == 0) halt = ~halt;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
